// File: rtl/writeback_unit.sv
// Write-back stage: buffers completed results in a DEPTH-entry FIFO, formats load data at push,
// and drains one register-file write per cycle. Define WB_FWD_EN to add the fwd_* bypass outputs.
module writeback_unit #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_sel,
  input  logic [31:0]      in_alu,
  input  logic [31:0]      in_load,
  input  logic [31:0]      in_pc4,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic             rf_hold,
  output logic             we,
  output logic [4:0]       waddr,
  output logic [31:0]      wbdata,
  output logic             hata,
  output logic [CNT_W-1:0] retired
`ifdef WB_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [31:0]      fwd_data
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             hata_q, hata_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [4:0]       rd_mem_q   [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];
  logic             err_mem_q  [DEPTH];

  logic             full, empty, push, pop;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;
  logic             head_err;

  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      fmt_data;
  logic             fmt_err;

  // Load formatting happens before the FIFO so the drain path is a plain mux.
  always_comb begin
    ld_byte  = '0;
    ld_half  = in_addr_lo[1] ? in_load[31:16] : in_load[15:0];
    fmt_data = in_alu;
    fmt_err  = 1'b0;
    case (in_addr_lo)
      2'd0:    ld_byte = in_load[7:0];
      2'd1:    ld_byte = in_load[15:8];
      2'd2:    ld_byte = in_load[23:16];
      default: ld_byte = in_load[31:24];
    endcase
    case (in_sel)
      2'd0: fmt_data = in_alu;
      2'd1: begin
        case (in_funct3)
          3'd0: fmt_data = {{24{ld_byte[7]}}, ld_byte};
          3'd4: fmt_data = {24'd0, ld_byte};
          3'd1: begin
            fmt_data = {{16{ld_half[15]}}, ld_half};
            fmt_err  = in_addr_lo[0];
          end
          3'd5: begin
            fmt_data = {16'd0, ld_half};
            fmt_err  = in_addr_lo[0];
          end
          3'd2: begin
            fmt_data = in_load;
            fmt_err  = (in_addr_lo != 2'd0);
          end
          default: begin
            fmt_data = in_load;
            fmt_err  = 1'b1;
          end
        endcase
      end
      2'd2:    fmt_data = in_pc4;
      default: fmt_data = in_imm;
    endcase
  end

  always_comb begin
    full      = (count_q == (AW+1)'(DEPTH));
    empty     = (count_q == '0);
    in_ready  = !full;
    push      = in_valid && !full;
    pop       = !empty && !rf_hold;
    head_rd   = rd_mem_q[rd_ptr_q];
    head_data = data_mem_q[rd_ptr_q];
    head_err  = err_mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    hata_d    = pop && head_err;
    retired_d = retired_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (pop && !head_err) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      hata_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      hata_q    <= hata_d;
      retired_q <= retired_d;
    end
  end

  // Entry storage needs no reset: only slots covered by count_q are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= in_rd;
      data_mem_q[wr_ptr_q] <= fmt_data;
      err_mem_q[wr_ptr_q]  <= (in_sel == 2'd1) && fmt_err;
    end
  end

  always_comb begin
    we      = pop && (head_rd != 5'd0) && !head_err;
    waddr   = empty ? '0 : head_rd;
    wbdata  = empty ? '0 : head_data;
    hata    = hata_q;
    retired = retired_q;
  end

`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_idx;

  // Scan oldest to youngest so the last qualifying slot wins.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    fwd_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + AW'(i);
      if (((AW+1)'(i) < count_q) && (rd_mem_q[fwd_idx] != 5'd0) && !err_mem_q[fwd_idx]) begin
        fwd_valid = 1'b1;
        fwd_rd    = rd_mem_q[fwd_idx];
        fwd_data  = data_mem_q[fwd_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed cases from the block description plus
// randomized traffic checked against a behavioural model of load formatting and FIFO order.
module tb_writeback_unit;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, rf_hold;
  logic [4:0]       in_rd;
  logic [1:0]       in_sel, in_addr_lo;
  logic [31:0]      in_alu, in_load, in_pc4, in_imm;
  logic [2:0]       in_funct3;
  logic             we, hata;
  logic [4:0]       waddr;
  logic [31:0]      wbdata;
  logic [CNT_W-1:0] retired;
`ifdef WB_FWD_EN
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [31:0]      fwd_data;
`endif

  always #5 clk = ~clk;

  writeback_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_sel(in_sel), .in_alu(in_alu), .in_load(in_load),
    .in_pc4(in_pc4), .in_imm(in_imm), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .rf_hold(rf_hold), .we(we), .waddr(waddr), .wbdata(wbdata), .hata(hata),
    .retired(retired)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu, load, pc4, imm;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic        hold;
  } stim_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] retired_exp = '0;
  logic        hata_exp = 1'b0;
  stim_t       cur_s;
  bit          cur_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick the addressed lane arithmetically, then extend by value range.
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    int unsigned off;
    logic [31:0] b, h;
    off    = s.alo;
    e.rd   = s.rd;
    e.err  = 1'b0;
    e.data = s.alu;
    b = (s.load >> (8 * off)) & 32'hFF;
    h = (s.load >> (16 * (off / 2))) & 32'hFFFF;
    case (s.sel)
      2'd0: e.data = s.alu;
      2'd2: e.data = s.pc4;
      2'd3: e.data = s.imm;
      default: begin
        case (s.f3)
          3'd0: e.data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
          3'd4: e.data = b;
          3'd1: begin e.data = (h >= 32768) ? h + 32'hFFFF_0000 : h; e.err = (off % 2 == 1); end
          3'd5: begin e.data = h; e.err = (off % 2 == 1); end
          3'd2: begin e.data = s.load; e.err = (off != 0); end
          default: begin e.data = s.load; e.err = 1'b1; end
        endcase
      end
    endcase
    return e;
  endfunction

  function automatic stim_t mk(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                               input logic [31:0] val, input logic [2:0] f3,
                               input logic [1:0] alo, input logic hold);
    stim_t s;
    s.v = v; s.rd = rd; s.sel = sel; s.alu = val; s.load = val;
    s.pc4 = 32'h0000_0104; s.imm = 32'hABCD_E000; s.f3 = f3; s.alo = alo; s.hold = hold;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.v    = ($urandom_range(9) < 7);
    s.hold = ($urandom_range(9) < 3);
    s.rd   = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
    s.sel  = 2'($urandom);
    s.alu  = $urandom; s.load = $urandom; s.pc4 = $urandom; s.imm = $urandom;
    s.f3   = 3'($urandom);
    s.alo  = 2'($urandom);
    return s;
  endfunction

  // Drive for this cycle, then sample acceptance at the falling edge.
  task automatic half_a(input stim_t s);
    in_valid = s.v; in_rd = s.rd; in_sel = s.sel; in_alu = s.alu; in_load = s.load;
    in_pc4 = s.pc4; in_imm = s.imm; in_funct3 = s.f3; in_addr_lo = s.alo; rf_hold = s.hold;
    cur_s = s;
    @(negedge clk);
    cur_acc = in_valid && in_ready && !reset;
  endtask

  task automatic half_b();
    @(posedge clk);
    if (cur_acc) sb.push_back(model(cur_s));
    #1;
  endtask

  task automatic cycle(input stim_t s);
    half_a(s);
    half_b();
  endtask

  // Monitor: every falling edge compare outputs against the scoreboard head.
  always @(negedge clk) begin
    exp_t h;
    bit   exp_pop;
    if (reset) begin
      sb.delete();
      retired_exp = '0;
      hata_exp    = 1'b0;
    end else begin
      exp_pop = (sb.size() > 0) && !rf_hold;
      chk("in_ready", in_ready, (sb.size() < DEPTH));
      chk("hata", hata, hata_exp);
      chk("retired", retired, retired_exp);
      if (sb.size() == 0) begin
        chk("we_empty", we, 0);
        chk("waddr_empty", waddr, 0);
        chk("wbdata_empty", wbdata, 0);
        hata_exp = 1'b0;
      end else begin
        h = sb[0];
        chk("we", we, exp_pop && (h.rd != 0) && !h.err);
        chk("waddr", waddr, h.rd);
        if (!h.err) chk("wbdata", wbdata, h.data);
        hata_exp = exp_pop && h.err;
        if (exp_pop) begin
          if (!h.err) retired_exp = retired_exp + 1;
          void'(sb.pop_front());
        end
      end
`ifdef WB_FWD_EN
      begin
        bit          fv;
        logic [4:0]  frd;
        logic [31:0] fd;
        fv = 0; frd = '0; fd = '0;
        foreach (sb[i]) if (sb[i].rd != 0 && !sb[i].err) begin fv = 1; frd = sb[i].rd; fd = sb[i].data; end
        chk("fwd_valid", fwd_valid, fv);
        if (fv) begin
          chk("fwd_rd", fwd_rd, frd);
          chk("fwd_data", fwd_data, fd);
        end
      end
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t idle, idle_h;
    int    acc_n;
    idle   = mk(0, 0, 0, 0, 0, 0, 0);
    idle_h = mk(0, 0, 0, 0, 0, 0, 1);
    reset  = 1'b1;
    half_a(idle);
    chk("reset_we", we, 0);
    half_b();
    repeat (2) cycle(idle);
    reset = 1'b0;
    cycle(idle);

    // ALU write with single-cycle latency
    cycle(mk(1, 5'd5, 2'd0, 32'h0000_1234, 0, 0, 0));
    half_a(idle);
    chk("alu_we", we, 1); chk("alu_waddr", waddr, 5); chk("alu_wbdata", wbdata, 32'h1234);
    half_b();
    half_a(idle);
    chk("alu_retired", retired, 1);
    half_b();

    // Byte and halfword lane extraction
    cycle(mk(1, 5'd3, 2'd1, 32'h80FF_7F01, 3'd0, 2'd3, 0));
    half_a(idle); chk("lb_we", we, 1); chk("lb_data", wbdata, 32'hFFFF_FF80); half_b();
    cycle(mk(1, 5'd3, 2'd1, 32'h80FF_7F01, 3'd4, 2'd3, 0));
    half_a(idle); chk("lbu_data", wbdata, 32'h0000_0080); half_b();
    cycle(mk(1, 5'd3, 2'd1, 32'h80FF_7F01, 3'd5, 2'd2, 0));
    half_a(idle); chk("lhu_data", wbdata, 32'h0000_80FF); half_b();

    // Misaligned LW: no write, one-cycle hata, retired unchanged
    cycle(mk(1, 5'd7, 2'd1, 32'h1111_2222, 3'd2, 2'd2, 0));
    half_a(idle); chk("lw_err_we", we, 0); half_b();
    half_a(mk(1, 5'd8, 2'd0, 32'h55, 0, 0, 0));
    chk("lw_err_hata", hata, 1); chk("lw_err_retired", retired, 4);
    half_b();
    half_a(idle); chk("after_err_hata", hata, 0); chk("after_err_we", we, 1); chk("after_err_waddr", waddr, 8);
    half_b();
    cycle(idle);

    // Hold: only DEPTH pushes accepted, then in-order drain
    acc_n = 0;
    half_a(mk(1, 5'd10, 2'd0, 32'hA, 0, 0, 1)); acc_n += cur_acc; half_b();
    half_a(mk(1, 5'd11, 2'd0, 32'hB, 0, 0, 1)); acc_n += cur_acc; half_b();
    half_a(mk(1, 5'd12, 2'd0, 32'hC, 0, 0, 1)); acc_n += cur_acc; half_b();
    chk("hold_accepted", acc_n, 2);
    half_a(idle_h); chk("hold_ready", in_ready, 0); chk("hold_we", we, 0); half_b();
    half_a(idle); chk("drain1_we", we, 1); chk("drain1_waddr", waddr, 10); chk("drain1_ready", in_ready, 0); half_b();
    half_a(idle); chk("drain2_ready", in_ready, 1); chk("drain2_waddr", waddr, 11); chk("drain2_data", wbdata, 32'hB); half_b();

    // rd==0 retires without writing
    cycle(mk(1, 5'd0, 2'd0, 32'hDEAD_BEEF, 0, 0, 0));
    half_a(idle); chk("x0_we", we, 0); half_b();
    half_a(idle); chk("x0_retired", retired, 8); half_b();

    for (int i = 0; i < 600; i++) cycle(rnd());
    repeat (4) cycle(idle);

    // Reset discards queued entries
    cycle(mk(1, 5'd20, 2'd0, 32'h20, 0, 0, 1));
    cycle(mk(1, 5'd21, 2'd0, 32'h21, 0, 0, 1));
    reset = 1'b1;
    cycle(idle_h);
    cycle(idle);
    reset = 1'b0;
    half_a(idle);
    chk("rst_we", we, 0); chk("rst_ready", in_ready, 1); chk("rst_retired", retired, 0);
`ifdef WB_FWD_EN
    chk("rst_fwd_valid", fwd_valid, 0);
`endif
    half_b();
    half_a(idle); chk("rst_we2", we, 0); chk("rst_waddr", waddr, 0); half_b();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
